// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter for the shared memory interconnect, with one-cycle bus turnaround between owners.
// Optional grant timeout is built when MEM_ARB_TIMEOUT_EN is defined.

module mem_bus_arbiter_chk #(
    parameter int NUM_REQ       = 4,
    parameter int GRANT_TIMEOUT = 8
) (
    input logic               clk,
    input logic               reset,
    input logic [NUM_REQ-1:0] grant,
    input logic               arb_busy
);

    a_params_legal: assert property (@(posedge clk)
        (NUM_REQ >= 2) && (NUM_REQ <= 8) && (GRANT_TIMEOUT >= 2) && (GRANT_TIMEOUT <= 255));

    a_grant_onehot: assert property (@(posedge clk) disable iff (!reset)
        $onehot0(grant));

    a_grant_implies_busy: assert property (@(posedge clk) disable iff (!reset)
        (grant != '0) |-> arb_busy);

    // A falling grant is followed by a turnaround cycle with the bus undriven.
    a_turnaround: assert property (@(posedge clk) disable iff (!reset)
        (grant != '0) ##1 (grant == '0) |=> (grant == '0));

endmodule

module mem_bus_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int GRANT_TIMEOUT = 8,
    localparam int IDX_W        = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               bus_busy,
    output logic [NUM_REQ-1:0] grant,
    output logic               arb_busy,
    output logic [IDX_W-1:0]   owner,
    output logic               timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               arb_busy_q, arb_busy_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W:0]     pick_s;
    logic               timeout_hit_s;

    // First requester after the rotation pointer; MSB flags that one was found.
    function automatic logic [IDX_W:0] pick_next(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   l);
        logic [IDX_W:0]   res;
        logic             found;
        logic [IDX_W-1:0] c;
        res   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            c = IDX_W'((int'(l) + k) % NUM_REQ);
            if (!found && r[c]) begin
                found = 1'b1;
                res   = {1'b1, c};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIM = 8'(GRANT_TIMEOUT);

    logic [7:0] cnt_q, cnt_d, cnt_inc_s;
    logic       timeout_err_q, timeout_err_d;

    assign cnt_inc_s     = (cnt_q == 8'hFF) ? cnt_q : (cnt_q + 8'd1);
    assign timeout_hit_s = (state_q == ST_GRANT) && !bus_busy && (cnt_inc_s == TIMEOUT_LIM);
    assign timeout_err_d = timeout_hit_s;

    // Wait counter: cleared while idle so every grant starts from zero, frozen once the owner is busy.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = 8'd0;
        end else if ((state_q == ST_GRANT) && !bus_busy) begin
            cnt_d = cnt_inc_s;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter and error pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q         <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_hit_s = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    assign pick_s = pick_next(req, last_q);

    // Next-state and grant decisions.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        last_d   = last_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus_busy && pick_s[IDX_W]) begin
                    state_d = ST_GRANT;
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s[IDX_W-1:0];
                    owner_d = pick_s[IDX_W-1:0];
                    last_d  = pick_s[IDX_W-1:0];
                end else begin
                    grant_d = '0;
                end
            end
            ST_GRANT: begin
                // Busy outranks both the timeout and a dropped request.
                if (bus_busy) begin
                    state_d = ST_BUSY;
                end else if (timeout_hit_s || !req[owner_q]) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            ST_BUSY: begin
                if (!bus_busy) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
        arb_busy_d = (state_d != ST_IDLE);
    end

    // Arbiter state registers; the pointer starts at the top so master 0 wins first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            arb_busy_q <= 1'b0;
            owner_q    <= '0;
            last_q     <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            arb_busy_q <= arb_busy_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
        end
    end

    assign grant    = grant_q;
    assign arb_busy = arb_busy_q;
    assign owner    = owner_q;

    mem_bus_arbiter_chk #(
        .NUM_REQ       (NUM_REQ),
        .GRANT_TIMEOUT (GRANT_TIMEOUT)
    ) u_chk (
        .clk      (clk),
        .reset    (reset),
        .grant    (grant_q),
        .arb_busy (arb_busy_q)
    );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: vector table, hand-written corner sequences, and random stimulus vs a reference model.
module tb_mem_bus_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       bus_busy;
    logic [3:0] grant;
    logic       arb_busy;
    logic [1:0] owner;
    logic       timeout_err;

    int errors = 0;
    int checks = 0;

    // Reference model: tenure phase 0=idle 1=granted 2=owner busy 3=turnaround
    int m_phase, m_owner, m_last, m_wait;
    bit m_terr;

    typedef struct packed {
        logic [3:0] req;
        logic       bb;
        logic [3:0] exp_grant;
        logic       exp_arb;
        logic [1:0] exp_owner;
    } vec_t;

    vec_t tbl [0:32];

    mem_bus_arbiter #(.NUM_REQ(N), .GRANT_TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .bus_busy    (bus_busy),
        .grant       (grant),
        .arb_busy    (arb_busy),
        .owner       (owner),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_owner = 0;
        m_last  = N - 1;
        m_wait  = 0;
        m_terr  = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic b);
        bit timed_out;
        m_terr = 1'b0;
        case (m_phase)
            0: if (!b && r != 4'b0000) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (r[c]) begin
                        m_owner = c;
                        break;
                    end
                end
                m_last  = m_owner;
                m_wait  = 0;
                m_phase = 1;
            end
            1: if (b) begin
                m_phase = 2;
            end else begin
                m_wait    = (m_wait < 255) ? m_wait + 1 : 255;
                timed_out = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                timed_out = (m_wait >= TO);
`endif
                if (timed_out) begin
                    m_phase = 3;
                    m_terr  = 1'b1;
                end else if (!r[m_owner]) begin
                    m_phase = 3;
                end
            end
            2: if (!b) m_phase = 3;
            default: m_phase = 0;
        endcase
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(req, bus_busy);
        #1;
    endtask

    task automatic do_reset();
        req      = 4'b0000;
        bus_busy = 1'b0;
        reset    = 1'b0;
        #3;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [3:0] exp_g;
        int         bad;

        tbl[0]  = '{4'b1011, 1'b0, 4'b0001, 1'b1, 2'd0};
        tbl[1]  = '{4'b1011, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[2]  = '{4'b1011, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[3]  = '{4'b1011, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[4]  = '{4'b1011, 1'b0, 4'b0000, 1'b1, 2'd0};
        tbl[5]  = '{4'b1011, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[6]  = '{4'b1011, 1'b0, 4'b0010, 1'b1, 2'd1};
        tbl[7]  = '{4'b1011, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[8]  = '{4'b1011, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[9]  = '{4'b1011, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[10] = '{4'b1011, 1'b0, 4'b0000, 1'b1, 2'd1};
        tbl[11] = '{4'b1011, 1'b0, 4'b0000, 1'b0, 2'd1};
        tbl[12] = '{4'b1011, 1'b0, 4'b1000, 1'b1, 2'd3};
        tbl[13] = '{4'b1011, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[14] = '{4'b1011, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[15] = '{4'b1011, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[16] = '{4'b1011, 1'b0, 4'b0000, 1'b1, 2'd3};
        tbl[17] = '{4'b1011, 1'b0, 4'b0000, 1'b0, 2'd3};
        tbl[18] = '{4'b1011, 1'b0, 4'b0001, 1'b1, 2'd0};
        // abandon: owner 0 drops, then master 2 granted and abandons; 3 must come next
        tbl[19] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd0};
        tbl[20] = '{4'b1100, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[21] = '{4'b1100, 1'b0, 4'b0100, 1'b1, 2'd2};
        tbl[22] = '{4'b1000, 1'b0, 4'b0000, 1'b1, 2'd2};
        tbl[23] = '{4'b1100, 1'b0, 4'b0000, 1'b0, 2'd2};
        tbl[24] = '{4'b1100, 1'b0, 4'b1000, 1'b1, 2'd3};
        // stray busy in idle, then busy and request drop together in GRANT
        tbl[25] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3};
        tbl[26] = '{4'b0100, 1'b1, 4'b0000, 1'b0, 2'd3};
        tbl[27] = '{4'b0100, 1'b1, 4'b0000, 1'b0, 2'd3};
        tbl[28] = '{4'b0100, 1'b1, 4'b0000, 1'b0, 2'd3};
        tbl[29] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2};
        tbl[30] = '{4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[31] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2};
        tbl[32] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2};

        // Reset behaviour with all masters requesting
        reset    = 1'b1;
        req      = 4'b1111;
        bus_busy = 1'b0;
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_grant", grant, 4'b0000);
        check("rst_arb_busy", arb_busy, 1'b0);
        check("rst_owner", owner, 2'd0);
        check("rst_timeout_err", timeout_err, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("first_grant", grant, 4'b0001);
        check("first_owner", owner, 2'd0);
        check("first_arb_busy", arb_busy, 1'b1);

        // Table-driven rotation / abandon / stray-busy vectors
        do_reset();
        foreach (tbl[i]) begin
            req      = tbl[i].req;
            bus_busy = tbl[i].bb;
            cycle();
            check($sformatf("vec%0d_grant", i), grant, tbl[i].exp_grant);
            check($sformatf("vec%0d_arb_busy", i), arb_busy, tbl[i].exp_arb);
            check($sformatf("vec%0d_owner", i), owner, tbl[i].exp_owner);
        end

        // Asynchronous reset while the owner is busy
        do_reset();
        req = 4'b0010;
        cycle();
        check("async_pre_grant", grant, 4'b0010);
        bus_busy = 1'b1;
        cycle();
        check("async_busy_grant", grant, 4'b0010);
        #2 reset = 1'b0;
        #1;
        check("async_grant", grant, 4'b0000);
        check("async_arb_busy", arb_busy, 1'b0);
        check("async_owner", owner, 2'd0);
        @(negedge clk);
        reset = 1'b1;

        // Grant held by a master that never drives the bus
        do_reset();
        req = 4'b0110;
        cycle();
        check("to_first_grant", grant, 4'b0010);
`ifdef MEM_ARB_TIMEOUT_EN
        for (int i = 1; i < TO; i++) begin
            cycle();
            check($sformatf("to_hold%0d_grant", i), grant, 4'b0010);
            check($sformatf("to_hold%0d_err", i), timeout_err, 1'b0);
        end
        cycle();
        check("to_revoke_grant", grant, 4'b0000);
        check("to_revoke_err", timeout_err, 1'b1);
        cycle();
        check("to_release_grant", grant, 4'b0000);
        check("to_err_pulse_end", timeout_err, 1'b0);
        cycle();
        check("to_next_grant", grant, 4'b0100);
        check("to_next_owner", owner, 2'd2);
`else
        bad = 0;
        repeat (120) begin
            cycle();
            if (grant !== 4'b0010 || timeout_err !== 1'b0) bad++;
        end
        check("no_timeout_hold_cycles_lost", bad, 0);
`endif

        // Random stimulus against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            if (((i / 400) % 2) == 0) bus_busy = ($urandom_range(0, 11) == 0);
            else                      bus_busy = ($urandom_range(0, 1) == 0);
            cycle();
            exp_g = (m_phase == 1 || m_phase == 2) ? (4'b0001 << m_owner) : 4'b0000;
            check("rnd_grant", grant, exp_g);
            check("rnd_arb_busy", arb_busy, (m_phase != 0));
            check("rnd_owner", owner, m_owner);
            check("rnd_timeout_err", timeout_err, m_terr);
            check("rnd_onehot0", $onehot0(grant), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Round-robin arbiter that shares the single memory interconnect (address/data tristate bus, `mem_req`/`mem_rd_wr`/`mem_en`) between the cache and memory masters, e.g. icache, dcache and DMA. It issues a one-hot registered grant, tracks bus ownership through the masters' busy handshake, and inserts one turnaround cycle between owners so the tristate drivers never overlap. It replaces a static daisy-chained grant with fair rotation.

## Interface
- `NUM_REQ`, 4: number of masters, legal range 2..8; index 0 is the highest priority after reset.
- `GRANT_TIMEOUT`, 8: maximum cycles a grant may wait for the owner's busy (only with the macro); legal range 2..255.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-master bus request, level-sensitive.
- `bus_busy`  in  1  OR of all masters' `bus_busy_out`; high while the owner drives the bus.
- `grant`  out  NUM_REQ  one-hot grant, registered; connects to each master's `grant_in`.
- `arb_busy`  out  1  high in GRANT, BUSY and RELEASE; connects to each master's `bus_busy_in`.
- `owner`  out  $clog2(NUM_REQ)  encoded index of the current/last grantee.
- `timeout_err`  out  1  one-cycle pulse on grant revocation; tied 0 without the macro.

## Operation
- Reset values: `grant`=0, `arb_busy`=0, `owner`=0, `timeout_err`=0, state=IDLE, rotation pointer `last`=NUM_REQ-1, timeout counter=0.
- States:
  - **IDLE**: if `bus_busy`=0 and any `req` bit is set, pick the first set bit searching `last+1, last+2, ...` mod NUM_REQ. Set `grant[i]`, set `owner`=i and `last`=i, then go to GRANT. While `bus_busy`=1, no grant is issued and the state stays IDLE, which protects against a stray driver.
  - **GRANT**: `grant[owner]` is held. If `bus_busy`=1, go to BUSY. Otherwise, if `req[owner]`=0, clear `grant` and go to RELEASE. When both occur in the same cycle, busy wins and the next state is BUSY.
  - **BUSY**: `grant` is held. Other `req` changes are ignored. When `bus_busy`=0, clear `grant` and go to RELEASE.
  - **RELEASE**: `grant`=0 for exactly one cycle (bus turnaround), then go to IDLE.
- The pointer updates only on entry to GRANT, so a revoked or abandoned owner still loses priority.
- Only the owner's `req` is examined after grant. Requests from other masters persist until they are served.
- `owner` holds its last value in IDLE/RELEASE. Use `arb_busy` to qualify it.
- `reset` asserted in any state forces the reset values immediately, independent of `clk`. The first grant after release goes to the lowest-index requester.

## Timing
- Request to grant: `req` sampled high at edge k means `grant` is high after edge k (1 cycle).
- Grant to owner: the master raises `bus_busy` at any later cycle. `arb_busy` rises with `grant`.
- Release: `bus_busy` sampled low at edge m means `grant` is low after edge m. RELEASE occupies edge m+1. The earliest next grant is after edge m+2.
- Back-to-back throughput: at least 2 idle-grant cycles between consecutive bus tenures.
- `grant` is never high for more than one master, and never high in IDLE or RELEASE.
- Counter width: 8 bits. It clears on entry to GRANT and saturates.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - In GRANT with `bus_busy`=0, the counter increments each cycle.
  - When it reaches `GRANT_TIMEOUT`, `grant` is cleared, `timeout_err` pulses for 1 cycle, and the state goes to RELEASE, even if `req[owner]` is still high.
  - Counting stops in BUSY.
- `MEM_ARB_TIMEOUT_EN` undefined:
  - No counter is built, and GRANT waits indefinitely while `req[owner]`=1.
  - `timeout_err` is constant 0.

## Test plan
- Reset: NUM_REQ=4, `req`=4'b1111 during and after `reset` release. Expect `grant`=0 while in reset, then `grant`=4'b0001 one cycle after the first edge and `owner`=0.
- Rotation: hold `req`=4'b1011. Each master raises `bus_busy` 1 cycle after its grant and drops it 3 cycles later. Expect grant order 0,1,3,0. Expect `grant`=0 for exactly one cycle between tenures, and never two bits set at once.
- Abandon: grant master 2, then drop `req[2]` before `bus_busy`. Expect `grant`=0 next cycle, one RELEASE cycle, then the next requester granted. Master 2 is not re-granted ahead of 3.
- Stray busy: force `bus_busy`=1 in IDLE with `req`=4'b0100. Expect no grant until `bus_busy`=0, then `grant`=4'b0100 one cycle later.
- Async reset mid-tenure: assert `reset` low between edges while in BUSY. Expect `grant`=0 and `arb_busy`=0 immediately, without waiting for `clk`.
- Timeout (macro on, GRANT_TIMEOUT=8): grant master 1, hold `req[1]`=1 and `bus_busy`=0. Expect a `timeout_err` pulse and `grant`=0 after 8 GRANT cycles, then master 2 granted if requesting. Macro off: `grant` stays asserted beyond 100 cycles.
